vga_axil_slave: RTL and testbench

AXI4-Lite responder exposing the VGA controller's four 32-bit control registers to the processing-system master. Accepts write address and write data independently, applies byte strobes, returns OKAY responses, and serves single-beat reads. Register contents drive the VGA timing/pixel logic directly. Sits between the AXI interconnect and the VGA core inside the VGA_Controller IP.

---
 rtl/vga_axil_pkg.sv | 30 +++
 rtl/vga_axil_slave.sv | 169 ++++++++++++++++
 tb/tb_vga_axil_slave.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_axil_pkg.sv
// vga_axil_pkg
// Shared constants for the VGA controller AXI4-Lite register block.
//   REG_*      : byte offsets of the four control registers
//   RESP_OKAY  : the only response this slave ever returns
//   IDX_W      : width of the word index taken from addr[3:2]
//   apply_strb : byte-lane merge of write data into an existing word
package vga_axil_pkg;

  localparam int unsigned IDX_W = 2;

  localparam logic [3:0] REG_CTRL  = 4'h0;
  localparam logic [3:0] REG_COLOR = 4'h4;
  localparam logic [3:0] REG_POS   = 4'h8;
  localparam logic [3:0] REG_STAT  = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Lanes with strb=1 take the new byte, the rest keep the old one.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_axil_slave.sv
// vga_axil_slave
// AXI4-Lite slave holding the four 32-bit VGA control registers.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET : clock, asynchronous active-high reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B* : write address, data, response channels
//   S_AXI_AR* / S_AXI_R*             : read address and data channels
//   reg0_o..reg3_o : live register contents to the VGA core
//   wr_pulse_o     : one-cycle pulse per register index after each commit
//   status_i       : VGA status word, only used with VGA_AXIL_STATUS_EN
// Configuration macro VGA_AXIL_STATUS_EN: offset 0xC becomes a read-only view
// of status_i; writes there are acknowledged but dropped and reg3_o stays 0.
module vga_axil_slave
  import vga_axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [31:0]                       reg0_o,
  output logic [31:0]                       reg1_o,
  output logic [31:0]                       reg2_o,
  output logic [31:0]                       reg3_o,
  output logic [3:0]                        wr_pulse_o,
  input  logic [31:0]                       status_i
);

  // Single-entry write address / write data buffers.
  logic             r_aw_full;
  logic [IDX_W-1:0] r_aw_idx;
  logic             r_w_full;
  logic [31:0]      r_w_data;
  logic [3:0]       r_w_strb;

  logic             r_bvalid;
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic [3:0]       r_wr_pulse;
  logic [31:0]      r_reg [4];

  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_ar_hs;
  logic             w_commit;
  logic             w_reg_we;
  logic [IDX_W-1:0] w_ar_idx;
  logic [31:0]      w_rd_val;
  logic             w_unused;

  assign w_aw_hs  = S_AXI_AWVALID & ~r_aw_full;
  assign w_w_hs   = S_AXI_WVALID & ~r_w_full;
  assign w_ar_hs  = S_AXI_ARVALID & ~r_rvalid;
  // A commit waits for any outstanding B response to be taken first.
  assign w_commit = r_aw_full & r_w_full & ~r_bvalid;
  assign w_ar_idx = S_AXI_ARADDR[IDX_W+1:2];

`ifdef VGA_AXIL_STATUS_EN
  assign w_reg_we = w_commit & (r_aw_idx != IDX_W'(3));
`else
  assign w_reg_we = w_commit;
`endif

  always_comb begin
    w_rd_val = r_reg[w_ar_idx];
`ifdef VGA_AXIL_STATUS_EN
    if (w_ar_idx == IDX_W'(3)) w_rd_val = status_i;
`endif
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_aw_full  <= 1'b0;
      r_aw_idx   <= '0;
      r_w_full   <= 1'b0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_bvalid   <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_wr_pulse <= '0;
      for (int i = 0; i < 4; i++) r_reg[i] <= '0;
    end else begin
      // Handshake needs an empty buffer, commit needs a full one: never both.
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= S_AXI_AWADDR[IDX_W+1:2];
      end else if (w_commit) begin
        r_aw_full <= 1'b0;
      end

      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= S_AXI_WDATA[31:0];
        r_w_strb <= S_AXI_WSTRB[3:0];
      end else if (w_commit) begin
        r_w_full <= 1'b0;
      end

      if (w_commit) begin
        r_bvalid <= 1'b1;
      end else if (S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end

      r_wr_pulse <= '0;
      for (int i = 0; i < 4; i++) begin
        if (w_reg_we && (r_aw_idx == IDX_W'(i))) begin
          r_reg[i]      <= apply_strb(r_reg[i], r_w_data, r_w_strb);
          r_wr_pulse[i] <= 1'b1;
        end
      end

      // Reads sample the pre-commit value when a commit shares the edge.
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_val;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = ~r_aw_full;
  assign S_AXI_WREADY  = ~r_w_full;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = ~r_rvalid;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = C_S_AXI_DATA_WIDTH'(r_rdata);
  assign S_AXI_RRESP   = RESP_OKAY;

  assign reg0_o     = r_reg[0];
  assign reg1_o     = r_reg[1];
  assign reg2_o     = r_reg[2];
`ifdef VGA_AXIL_STATUS_EN
  assign reg3_o     = '0;
`else
  assign reg3_o     = r_reg[3];
`endif
  assign wr_pulse_o = r_wr_pulse;

`ifdef VGA_AXIL_STATUS_EN
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                      S_AXI_WDATA, S_AXI_WSTRB};
`else
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                      S_AXI_WDATA, S_AXI_WSTRB, status_i};
`endif

endmodule

// File: tb/tb_vga_axil_slave.sv
// tb_vga_axil_slave
// Directed bench for vga_axil_slave. Inputs are driven and outputs sampled on
// the falling clock edge. Honours VGA_AXIL_STATUS_EN for the 0xC expectations.
module tb_vga_axil_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  wr_pulse;
  logic [31:0] status = 32'hDEADBEEF;

  int tests = 0;
  int fails = 0;
  int pulse_cnt [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  vga_axil_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg0_o        (reg0),
    .reg1_o        (reg1),
    .reg2_o        (reg2),
    .reg3_o        (reg3),
    .wr_pulse_o    (wr_pulse),
    .status_i      (status)
  );

  // Pre-edge value is read here, so each registered pulse is counted once.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_pulse[i] === 1'b1) pulse_cnt[i] = pulse_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input string tag);
    int n;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    check({tag, "_awready"}, 32'(awready), 32'd1);
    check({tag, "_wready"}, 32'(wready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_blat"}, 32'(n), 32'd1);
    check({tag, "_bresp"}, 32'(bresp), 32'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    check({tag, "_arready"}, 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, rdata, exp);
    check({tag, "_rresp"}, 32'(rresp), 32'd0);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check({tag, "_arready_after"}, 32'(arready), 32'd1);
  endtask

  initial begin
    logic [31:0] exp_c;
    logic [31:0] exp_reg3;
    int          exp_p3;
    int          snap2;

`ifdef VGA_AXIL_STATUS_EN
    exp_c    = 32'hDEADBEEF;
    exp_reg3 = 32'h0;
    exp_p3   = 0;
`else
    exp_c    = 32'h0;
    exp_reg3 = 32'h4;
    exp_p3   = 1;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
    check("rst_pulse", 32'(wr_pulse), 32'd0);
    rst = 1'b0;

    axi_read(4'h0, 32'h0, "rd0_init");
    axi_read(4'h4, 32'h0, "rd4_init");
    axi_read(4'h8, 32'h0, "rd8_init");
    axi_read(4'hC, exp_c, "rdC_init");

    // Fill all four registers
    axi_write(4'h0, 32'h1, 4'hF, "wr0");
    axi_write(4'h4, 32'h2, 4'hF, "wr4");
    axi_write(4'h8, 32'h3, 4'hF, "wr8");
    axi_write(4'hC, 32'h4, 4'hF, "wrC");
    `ifdef VGA_AXIL_STATUS_EN
    exp_c = 32'hDEADBEEF;
    `else
    exp_c = 32'h4;
    `endif
    axi_read(4'h0, 32'h1, "rd0");
    axi_read(4'h4, 32'h2, "rd4");
    axi_read(4'h8, 32'h3, "rd8");
    axi_read(4'hC, exp_c, "rdC");
    check("reg3_out", reg3, exp_reg3);
    check("pulse_cnt0", 32'(pulse_cnt[0]), 32'd1);
    check("pulse_cnt1", 32'(pulse_cnt[1]), 32'd1);
    check("pulse_cnt2", 32'(pulse_cnt[2]), 32'd1);
    check("pulse_cnt3", 32'(pulse_cnt[3]), 32'(exp_p3));

    // W first, AW three cycles later
    @(negedge clk);
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("split_wready_c1", 32'(wready), 32'd0);
    @(negedge clk);
    check("split_wready_c2", 32'(wready), 32'd0);
    check("split_bvalid_c2", 32'(bvalid), 32'd0);
    @(negedge clk);
    check("split_awready_c3", 32'(awready), 32'd1);
    awaddr = 4'h4; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("split_bvalid_c4", 32'(bvalid), 32'd0);
    check("split_wready_c4", 32'(wready), 32'd0);
    check("split_reg1_pre", reg1, 32'h2);
    @(negedge clk);
    check("split_bvalid", 32'(bvalid), 32'd1);
    check("split_reg1", reg1, 32'hA5A5A5A5);
    check("split_pulse", 32'(wr_pulse), 32'b0010);
    check("split_wready_done", 32'(wready), 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;

    // Byte strobes
    axi_write(4'h4, 32'hFFFFFFFF, 4'hF, "strb_fill");
    axi_write(4'h4, 32'h12345678, 4'b0101, "strb_part");
    check("strb_reg1", reg1, 32'hFF34FF78);
    axi_read(4'h4, 32'hFF34FF78, "strb_rd");

    // BREADY held low with a second write queued
    snap2 = pulse_cnt[2];
    @(negedge clk);
    awaddr = 4'h8; awvalid = 1'b1; wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("bp_bvalid1", 32'(bvalid), 32'd1);
    check("bp_reg2_a", reg2, 32'h11111111);
    awvalid = 1'b1; wdata = 32'h22222222; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bp_awready_held", 32'(awready), 32'd0);
    repeat (10) @(negedge clk);
    check("bp_reg2_hold", reg2, 32'h11111111);
    check("bp_bvalid_hold", 32'(bvalid), 32'd1);
    check("bp_pulse_once", 32'(pulse_cnt[2] - snap2), 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bp_bvalid_clr", 32'(bvalid), 32'd0);
    check("bp_reg2_not_yet", reg2, 32'h11111111);
    @(negedge clk);
    check("bp_bvalid2", 32'(bvalid), 32'd1);
    check("bp_reg2_b", reg2, 32'h22222222);
    check("bp_pulse2", 32'(wr_pulse), 32'b0100);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bp_pulse_twice", 32'(pulse_cnt[2] - snap2), 32'd2);

    // RDATA held while RREADY low, with a concurrent write to the same register
    @(negedge clk);
    araddr = 4'h8; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    axi_write(4'h8, 32'h33333333, 4'hF, "rdhold_wr");
    check("rdhold_rvalid", 32'(rvalid), 32'd1);
    check("rdhold_rdata", rdata, 32'h22222222);
    check("rdhold_arready", 32'(arready), 32'd0);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    axi_read(4'h8, 32'h33333333, "rdhold_new");

    // Status register view / plain register at 0xC
    axi_write(4'hC, 32'h55, 4'hF, "wrC55");
`ifdef VGA_AXIL_STATUS_EN
    axi_read(4'hC, 32'hDEADBEEF, "stat_rd");
    check("stat_reg3", reg3, 32'h0);
`else
    axi_read(4'hC, 32'h55, "regC_rd");
    check("regC_reg3", reg3, 32'h55);
`endif

    // Reset in the middle of a write discards the buffered address
    @(negedge clk);
    awaddr = 4'h0; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("mid_awready_busy", 32'(awready), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_awready_rst", 32'(awready), 32'd1);
    check("mid_reg0_rst", reg0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    axi_write(4'h0, 32'h77, 4'hF, "post_rst_wr");
    check("post_rst_reg0", reg0, 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
